// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types: register width and the
// control bundle that rides along with each vector operation.
package riscv_v_pkg;

  localparam int VLEN = 64;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] sew;
    logic       vm;
  } execution_vector_t;

endpackage

// File: rtl/vector_multiply_issue_buffer_if.sv
// Upstream operand and downstream result valid/ready channels
// of the multiply issue buffer; slave = buffer, master = its peers.
interface vector_multiply_issue_buffer_if #(
  parameter int TAG_W = 4
);
  import riscv_v_pkg::*;

  logic              in_valid;
  logic              in_ready;
  execution_vector_t in_execution_vector;
  logic [VLEN-1:0]   in_vs2;
  logic [VLEN-1:0]   in_vs1;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [VLEN-1:0]   out_vd;
  logic [TAG_W-1:0]  out_tag;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_execution_vector,
    input  in_vs2,
    input  in_vs1,
    input  in_tag,
    output out_valid,
    input  out_ready,
    output out_vd,
    output out_tag
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_execution_vector,
    output in_vs2,
    output in_vs1,
    output in_tag,
    input  out_valid,
    output out_ready,
    input  out_vd,
    input  out_tag
  );

endinterface

// File: rtl/vector_multiply_issue_buffer.sv
// Operand queue -> credit-gated issue into a fixed-latency multiplier ->
// in-order result queue. Ports: clock/reset/flush, io (in/out channels), mul_*, busy.
module vector_multiply_issue_buffer
  import riscv_v_pkg::*;
#(
  parameter int OPQ_DEPTH   = 4,
  parameter int RESQ_DEPTH  = 4,
  parameter int MUL_LATENCY = 2,
  parameter int TAG_W       = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  vector_multiply_issue_buffer_if.slave io,
  output execution_vector_t    mul_execution_vector,
  output logic [VLEN-1:0]      mul_vs2,
  output logic [VLEN-1:0]      mul_vs1,
  input  logic [VLEN-1:0]      mul_vd,
  output logic                 busy
);

  localparam int OPW = $clog2(OPQ_DEPTH);
  localparam int OCW = $clog2(OPQ_DEPTH + 1);
  localparam int RSW = $clog2(RESQ_DEPTH);
  localparam int RCW = $clog2(RESQ_DEPTH + 1);
  localparam int ICW = $clog2(MUL_LATENCY + 1);

  logic [OPW-1:0]    opq_head;
  logic [OPW-1:0]    opq_tail;
  logic [OCW-1:0]    opq_count;
  execution_vector_t opq_ev  [OPQ_DEPTH];
  logic [VLEN-1:0]   opq_vs2 [OPQ_DEPTH];
  logic [VLEN-1:0]   opq_vs1 [OPQ_DEPTH];
  logic [TAG_W-1:0]  opq_tag [OPQ_DEPTH];

  logic [MUL_LATENCY-1:0] trk_v;
  logic [TAG_W-1:0]       trk_tag [MUL_LATENCY];
  logic [ICW-1:0]         inflight_count;

  logic [RSW-1:0]   res_head;
  logic [RSW-1:0]   res_tail;
  logic [RCW-1:0]   res_count;
  logic [VLEN-1:0]  res_vd  [RESQ_DEPTH];
  logic [TAG_W-1:0] res_tag [RESQ_DEPTH];

  logic clear;
  logic in_ready;
  logic push;
  logic credit_ok;
  logic issue;
  logic res_wr;
  logic res_rd;
  logic out_valid;

  always_comb begin
    inflight_count = '0;
    for (int i = 0; i < MUL_LATENCY; i++) begin
      inflight_count = inflight_count + ICW'(trk_v[i]);
    end
  end

  // A slot is reserved from issue until the result is dequeued,
  // so a returning vd always finds room in the result queue.
  always_comb begin
    clear     = reset | flush;
    in_ready  = !reset && (int'(opq_count) != OPQ_DEPTH);
    push      = io.in_valid && in_ready && !flush;
    credit_ok = (int'(inflight_count) + int'(res_count))
                < RESQ_DEPTH;
    issue     = !clear && (opq_count != '0) && credit_ok;
    res_wr    = trk_v[MUL_LATENCY-1];
    out_valid = (res_count != '0);
    res_rd    = out_valid && io.out_ready;
  end

  always_comb begin
    mul_execution_vector = '0;
    mul_vs2              = '0;
    mul_vs1              = '0;
    if (issue) begin
      mul_execution_vector = opq_ev[opq_head];
      mul_vs2              = opq_vs2[opq_head];
      mul_vs1              = opq_vs1[opq_head];
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      opq_head  <= '0;
      opq_tail  <= '0;
      opq_count <= '0;
    end else begin
      if (push) opq_tail <= opq_tail + 1'b1;
      if (issue) opq_head <= opq_head + 1'b1;
      unique case ({push, issue})
        2'b10:   opq_count <= opq_count + 1'b1;
        2'b01:   opq_count <= opq_count - 1'b1;
        default: opq_count <= opq_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      opq_ev[opq_tail]  <= io.in_execution_vector;
      opq_vs2[opq_tail] <= io.in_vs2;
      opq_vs1[opq_tail] <= io.in_vs1;
      opq_tag[opq_tail] <= io.in_tag;
    end
  end

  // Clearing the valids is what discards a late mul_vd.
  always_ff @(posedge clock) begin
    if (clear) begin
      trk_v <= '0;
    end else begin
      trk_v[0] <= issue;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        trk_v[i] <= trk_v[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    trk_tag[0] <= opq_tag[opq_head];
    for (int i = 1; i < MUL_LATENCY; i++) begin
      trk_tag[i] <= trk_tag[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      res_head  <= '0;
      res_tail  <= '0;
      res_count <= '0;
    end else begin
      if (res_wr) res_tail <= res_tail + 1'b1;
      if (res_rd) res_head <= res_head + 1'b1;
      unique case ({res_wr, res_rd})
        2'b10:   res_count <= res_count + 1'b1;
        2'b01:   res_count <= res_count - 1'b1;
        default: res_count <= res_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (res_wr) begin
      res_vd[res_tail]  <= mul_vd;
      res_tag[res_tail] <= trk_tag[MUL_LATENCY-1];
    end
  end

  always_comb begin
    io.in_ready  = in_ready;
    io.out_valid = out_valid;
    io.out_vd    = out_valid ? res_vd[res_head] : '0;
    io.out_tag   = out_valid ? res_tag[res_head] : '0;
    busy         = (opq_count != '0) ||
                   (inflight_count != '0) ||
                   (res_count != '0);
  end

endmodule

// File: tb/tb_vector_multiply_issue_buffer.sv
// Scoreboard bench: monitor pushes expected {vd,tag} on each accepted
// op and pops/compares on each result handshake; models the 2-cycle multiplier.
module tb_vector_multiply_issue_buffer;
  import riscv_v_pkg::*;

  localparam int TW = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush;
  execution_vector_t mul_ev;
  logic [VLEN-1:0]   mul_vs2;
  logic [VLEN-1:0]   mul_vs1;
  logic [VLEN-1:0]   mul_vd;
  logic              busy;

  vector_multiply_issue_buffer_if #(.TAG_W(TW)) bus ();

  vector_multiply_issue_buffer #(
    .OPQ_DEPTH  (4),
    .RESQ_DEPTH (4),
    .MUL_LATENCY(2),
    .TAG_W      (TW)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .flush               (flush),
    .io                  (bus),
    .mul_execution_vector(mul_ev),
    .mul_vs2             (mul_vs2),
    .mul_vs1             (mul_vs1),
    .mul_vd              (mul_vd),
    .busy                (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [VLEN-1:0] mul_ref(
    input execution_vector_t ev,
    input logic [VLEN-1:0] a,
    input logic [VLEN-1:0] b
  );
    logic [2*VLEN-1:0] p;
    p = {{VLEN{1'b0}}, a} * {{VLEN{1'b0}}, b};
    return ev.op[0] ? p[2*VLEN-1:VLEN] : p[VLEN-1:0];
  endfunction

  logic [VLEN-1:0] p1 = '0;
  logic [VLEN-1:0] p2 = '0;
  always @(posedge clock) begin
    p1 <= mul_ref(mul_ev, mul_vs2, mul_vs1);
    p2 <= p1;
  end
  assign mul_vd = p2;

  typedef struct {
    logic [VLEN-1:0] vd;
    logic [TW-1:0]   tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   out_cycles[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   n_issue = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        e.vd  = mul_ref(bus.in_execution_vector,
                        bus.in_vs2, bus.in_vs1);
        e.tag = bus.in_tag;
        exp_q.push_back(e);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        out_cycles.push_back(cyc);
        chk("out_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_vd", bus.out_vd, e.vd);
          chk("out_tag", 64'(bus.out_tag), 64'(e.tag));
        end
      end
    end
    if (mul_vs1 != '0) n_issue++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input logic [TW-1:0] tag);
    bus.in_execution_vector = execution_vector_t'($urandom);
    bus.in_vs2 = {$urandom, $urandom};
    bus.in_vs1 = {$urandom, $urandom} | 64'd1;
    bus.in_tag = tag;
  endtask

  task automatic drain(input string nm, input int budget);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < budget; k++) begin
      if (exp_q.size() == 0 && !busy) break;
      tick();
    end
    chk(nm, 64'({exp_q.size() == 0, busy}), 64'd2);
  endtask

  task automatic single_op(input string pre, input logic [TW-1:0] tag);
    int t0;
    int tout;
    bus.out_ready = 1'b1;
    set_op(tag);
    bus.in_valid = 1'b1;
    #3;
    chk({pre, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({pre, "_mul_idle"}, mul_vs1, 64'd0);
    t0 = cyc;
    tick();
    bus.in_valid = 1'b0;
    tout = -1;
    for (int k = 1; k <= 8; k++) begin
      #3;
      if (k == 1) chk({pre, "_mul_issue"}, 64'(mul_vs1 != '0), 64'd1);
      if (k == 2) chk({pre, "_mul_bubble"}, mul_vs1, 64'd0);
      if (k == 4) chk({pre, "_busy_hold"}, 64'(busy), 64'd1);
      if (k == 5) chk({pre, "_busy_drop"}, 64'(busy), 64'd0);
      if (bus.out_valid && tout < 0) begin
        tout = cyc;
        chk({pre, "_tag"}, 64'(bus.out_tag), 64'(tag));
      end
      tick();
    end
    chk({pre, "_latency"}, 64'(tout - t0), 64'd4);
  endtask

  int sent;
  int loaded;
  int n0;
  int i0;
  logic acc;

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_op('0);
    tick();
    tick();
    #3;
    chk("rst_in_ready_low", 64'(bus.in_ready), 64'd0);
    tick();
    reset = 1'b0;
    #3;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_vd", bus.out_vd, 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mul", mul_vs2 | mul_vs1 | 64'(mul_ev), 64'd0);
    tick();

    single_op("single", 4'd3);

    // back-to-back, full rate
    out_cycles.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_op(TW'(i));
      bus.in_valid = 1'b1;
      #3;
      chk("b2b_in_ready", 64'(bus.in_ready), 64'd1);
      tick();
    end
    drain("b2b_drain", 20);
    chk("b2b_count", 64'(out_cycles.size()), 64'd8);
    if (out_cycles.size() == 8)
      chk("b2b_spacing", 64'(out_cycles[7] - out_cycles[0]), 64'd7);

    // backpressure
    bus.out_ready = 1'b0;
    i0 = n_issue;
    n0 = n_out;
    sent = 0;
    loaded = -1;
    for (int c = 0; c < 16; c++) begin
      if (sent < 10) begin
        if (loaded != sent) begin
          set_op(TW'(sent));
          loaded = sent;
        end
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) sent++;
    end
    #3;
    chk("bp_issued", 64'(n_issue - i0), 64'd4);
    chk("bp_accepted", 64'(sent), 64'd8);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    drain("bp_drain", 40);
    chk("bp_results", 64'(n_out - n0), 64'd8);

    // random stalls across pointer wrap
    n0 = n_out;
    sent = 0;
    loaded = -1;
    for (int c = 0; c < 400 && sent < 20; c++) begin
      if (loaded != sent) begin
        set_op(TW'(sent));
        loaded = sent;
      end
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.out_ready = $urandom_range(0, 1) == 1;
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) sent++;
    end
    chk("wrap_sent", 64'(sent), 64'd20);
    drain("wrap_drain", 60);
    chk("wrap_results", 64'(n_out - n0), 64'd20);

    // flush with work in every stage
    bus.out_ready = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 5; i++) begin
      set_op(TW'(i));
      bus.in_valid = 1'b1;
      tick();
    end
    set_op(4'd9);
    flush = 1'b1;
    #3;
    chk("fl_pre_busy", 64'(busy), 64'd1);
    chk("fl_pre_out_valid", 64'(bus.out_valid), 64'd1);
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    #3;
    chk("fl_busy", 64'(busy), 64'd0);
    chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    chk("fl_no_output", 64'(n_out - n0), 64'd0);
    chk("fl_idle_busy", 64'(busy), 64'd0);

    // reset mid-stream
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(TW'(i + 5));
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    n0 = n_out;
    #3;
    chk("mr_in_ready_low", 64'(bus.in_ready), 64'd0);
    tick();
    reset = 1'b0;
    #3;
    chk("mr_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_out_vd", bus.out_vd, 64'd0);
    chk("mr_out_tag", 64'(bus.out_tag), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_mul", mul_vs2 | mul_vs1, 64'd0);
    for (int k = 0; k < 6; k++) tick();
    chk("mr_no_output", 64'(n_out - n0), 64'd0);
    single_op("post_rst", 4'd11);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
